// File: rtl/sound_pkg.sv
// Shared definitions for the sound engine: operating modes, default timing
// constants and the saturating half-period sweep step.
package sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2
    } state_e;

    localparam int unsigned HP_W          = 16;
    localparam int unsigned DEF_P_INIT    = 25000;
    localparam int unsigned DEF_P_MIN     = 5000;
    localparam int unsigned DEF_P_MAX     = 60000;
    localparam int unsigned DEF_STEP      = 250;
    localparam int unsigned DEF_SWEEP_DIV = 50000;
    localparam int unsigned DEF_DUR       = 12500000;

    // Headroom is tested before stepping, so the 16-bit value never wraps.
    function automatic logic [HP_W-1:0] sweep_step(
        input logic [HP_W-1:0] cur,
        input logic            up,
        input logic            down,
        input logic [HP_W-1:0] p_min,
        input logic [HP_W-1:0] p_max,
        input logic [HP_W-1:0] step
    );
        logic [HP_W-1:0] res;
        res = cur;
        if (up && !down) begin
            if (cur >= p_min && (cur - p_min) >= step) begin
                res = cur - step;
            end else begin
                res = p_min;
            end
        end else if (down && !up) begin
            if (cur <= p_max && (p_max - cur) >= step) begin
                res = cur + step;
            end else begin
                res = p_max;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: counts one half-period, toggles the tone bit on wrap
// and only picks up a new half-period at that wrap so no half-cycle is cut short.
module tone_divider
    import sound_pkg::*;
#(
    parameter logic [HP_W-1:0] INIT_HALF = HP_W'(DEF_P_INIT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [HP_W-1:0] half_period,
    output logic            tone
);

    logic [HP_W-1:0] cnt_q;
    logic [HP_W-1:0] cnt_d;
    logic [HP_W-1:0] active_q;
    logic [HP_W-1:0] active_d;
    logic            tone_q;
    logic            tone_d;

    always_comb begin
        cnt_d    = cnt_q;
        tone_d   = tone_q;
        active_d = active_q;
        if (clr || !en) begin
            // Parked: track the requested half-period so a fresh tone starts with it.
            cnt_d    = '0;
            tone_d   = 1'b0;
            active_d = half_period;
        end else if (cnt_q >= active_q - HP_W'(1)) begin
            cnt_d    = '0;
            tone_d   = ~tone_q;
            active_d = half_period;
        end else begin
            cnt_d    = cnt_q + HP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            tone_q   <= 1'b0;
            active_q <= INIT_HALF;
        end else begin
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            active_q <= active_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/sound_engine.sv
// Tone generator with swept pitch and a duration timer that pulses conto at the
// end of every interval while cuente is held.
module sound_engine
    import sound_pkg::*;
#(
    parameter int unsigned P_INIT    = DEF_P_INIT,
    parameter int unsigned P_MIN     = DEF_P_MIN,
    parameter int unsigned P_MAX     = DEF_P_MAX,
    parameter int unsigned STEP      = DEF_STEP,
    parameter int unsigned SWEEP_DIV = DEF_SWEEP_DIV,
    parameter int unsigned DUR       = DEF_DUR
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            reset_sonido,
    input  logic            fre_up,
    input  logic            fre_down,
    input  logic            cuente,
    input  logic            suene,
    output logic            conto,
    output logic            speaker,
    output logic [HP_W-1:0] period
);

    localparam int unsigned PRE_W = $clog2(SWEEP_DIV + 1);
    localparam int unsigned DUR_W = $clog2(DUR + 1);

    localparam logic [HP_W-1:0]  INIT_HP  = HP_W'(P_INIT);
    localparam logic [HP_W-1:0]  MIN_HP   = HP_W'(P_MIN);
    localparam logic [HP_W-1:0]  MAX_HP   = HP_W'(P_MAX);
    localparam logic [HP_W-1:0]  STEP_HP  = HP_W'(STEP);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SWEEP_DIV - 1);
    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR - 1);

    state_e           state_q;
    state_e           state_d;
    logic [HP_W-1:0]  period_q;
    logic [HP_W-1:0]  period_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [DUR_W-1:0] dur_cnt_q;
    logic [DUR_W-1:0] dur_cnt_d;
    logic             dur_run_q;
    logic             dur_run_d;
    logic             conto_q;
    logic             conto_d;
    logic             tone_en;
    logic             tone;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            period_q  <= INIT_HP;
            pre_q     <= '0;
            dur_cnt_q <= '0;
            dur_run_q <= 1'b0;
            conto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            pre_q     <= pre_d;
            dur_cnt_q <= dur_cnt_d;
            dur_run_q <= dur_run_d;
            conto_q   <= conto_d;
        end
    end

    always_comb begin
        state_d   = ST_IDLE;
        period_d  = period_q;
        pre_d     = pre_q;
        dur_cnt_d = dur_cnt_q;
        dur_run_d = dur_run_q;
        conto_d   = 1'b0;

        if (reset_sonido) begin
            state_d = ST_IDLE;
        end else if (suene) begin
            state_d = ST_PLAY;
        end else begin
            state_d = ST_ARMED;
        end

        if (state_d == ST_IDLE) begin
            period_d  = INIT_HP;
            pre_d     = '0;
            dur_cnt_d = '0;
            dur_run_d = 1'b0;
        end else begin
            if (pre_q == PRE_LAST) begin
                pre_d    = '0;
                period_d = sweep_step(period_q, fre_up, fre_down, MIN_HP, MAX_HP, STEP_HP);
            end else begin
                pre_d    = pre_q + PRE_W'(1);
            end

            // The first high sample only opens the interval, so the first pulse
            // lands DUR cycles after it rather than DUR-1.
            if (!cuente) begin
                dur_cnt_d = '0;
                dur_run_d = 1'b0;
            end else if (!dur_run_q) begin
                dur_cnt_d = '0;
                dur_run_d = 1'b1;
            end else if (dur_cnt_q == DUR_LAST) begin
                dur_cnt_d = '0;
                conto_d   = 1'b1;
            end else begin
                dur_cnt_d = dur_cnt_q + DUR_W'(1);
            end
        end
    end

    assign tone_en = (state_d == ST_PLAY);

    // Fed with the next half-period so a wrap on a sweep-tick cycle latches the new value.
    tone_divider #(
        .INIT_HALF (INIT_HP)
    ) u_tone (
        .clk         (CLK),
        .rst         (RST),
        .clr         (reset_sonido),
        .en          (tone_en),
        .half_period (period_d),
        .tone        (tone)
    );

    assign speaker = tone & (state_q == ST_PLAY);
    assign conto   = conto_q;
    assign period  = period_q;

endmodule

// File: tb/tb_sound_engine.sv
// Randomised and directed bench for sound_engine against a cycle-count reference model.
module tb_sound_engine;

    localparam int P_INIT    = 10;
    localparam int P_MIN     = 4;
    localparam int P_MAX     = 20;
    localparam int STEP      = 2;
    localparam int SWEEP_DIV = 5;
    localparam int DUR       = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        reset_sonido;
    logic        fre_up;
    logic        fre_down;
    logic        cuente;
    logic        suene;
    logic        conto;
    logic        speaker;
    logic [15:0] period;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed-cycle counts since the last clear of each activity.
    int   m_per;
    int   m_age;
    int   m_since;
    int   m_half;
    int   m_run;
    logic m_tone;
    logic m_conto;

    sound_engine #(
        .P_INIT    (P_INIT),
        .P_MIN     (P_MIN),
        .P_MAX     (P_MAX),
        .STEP      (STEP),
        .SWEEP_DIV (SWEEP_DIV),
        .DUR       (DUR)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .reset_sonido (reset_sonido),
        .fre_up       (fre_up),
        .fre_down     (fre_down),
        .cuente       (cuente),
        .suene        (suene),
        .conto        (conto),
        .speaker      (speaker),
        .period       (period)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_per   = P_INIT;
        m_age   = 0;
        m_since = 0;
        m_half  = P_INIT;
        m_run   = 0;
        m_tone  = 1'b0;
        m_conto = 1'b0;
    endtask

    task automatic model_edge();
        if (reset_sonido) begin
            model_reset();
        end else begin
            m_age++;
            if (m_age % SWEEP_DIV == 0) begin
                if (fre_up && !fre_down) m_per = (m_per - STEP >= P_MIN) ? m_per - STEP : P_MIN;
                else if (fre_down && !fre_up) m_per = (m_per + STEP <= P_MAX) ? m_per + STEP : P_MAX;
            end
            if (suene) begin
                m_since++;
                if (m_since == m_half) begin
                    m_tone  = ~m_tone;
                    m_since = 0;
                    m_half  = m_per;
                end
            end else begin
                m_since = 0;
                m_tone  = 1'b0;
                m_half  = m_per;
            end
            if (cuente) begin
                m_run++;
                m_conto = (m_run > 1) && ((m_run - 1) % DUR == 0);
            end else begin
                m_run   = 0;
                m_conto = 1'b0;
            end
        end
    endtask

    // One clock edge: model follows the inputs sampled at the edge, outputs settle by +1.
    task automatic advance();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic soft_clear_pulse();
        reset_sonido = 1'b1;
        advance();
        reset_sonido = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (speaker !== 1'b0 || conto !== 1'b0 || period !== 16'd10) begin
            $display("FAIL reset_hold: got spk=%b conto=%b period=%0d, want spk=0 conto=0 period=10", speaker, conto, period);
        end else n_pass++;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        model_reset();
        advance();
        n_checks++;
        if (speaker !== 1'b0 || conto !== 1'b0 || period !== 16'd10) begin
            $display("FAIL reset_release: got spk=%b conto=%b period=%0d, want spk=0 conto=0 period=10", speaker, conto, period);
        end else n_pass++;
        $display("[reset] done");
    endtask

    task automatic test_tone();
        int   toggles[$];
        logic prev;
        soft_clear_pulse();
        suene = 1'b1;
        prev  = speaker;
        for (int i = 0; i < 45; i++) begin
            advance();
            n_checks++;
            if (speaker !== m_tone || conto !== m_conto || period !== 16'(m_per)) begin
                $display("FAIL tone_cyc%0d: got spk=%b conto=%b period=%0d, want spk=%b conto=%b period=%0d",
                         i, speaker, conto, period, m_tone, m_conto, m_per);
            end else n_pass++;
            if (speaker !== prev) toggles.push_back(i);
            prev = speaker;
        end
        n_checks++;
        if (toggles.size() != 4 || toggles[0] != 9 || toggles[1] != 19 || toggles[2] != 29 || toggles[3] != 39) begin
            $display("FAIL tone_toggles: got %0d toggles first at %0d, want 4 toggles at 9/19/29/39",
                     toggles.size(), (toggles.size() > 0) ? toggles[0] : -1);
        end else n_pass++;
        $display("[tone] done");
    endtask

    task automatic test_sweep_up();
        int   toggles[$];
        logic prev;
        int   exp_idx[5] = '{0, 4, 9, 14, 19};
        int   exp_val[5] = '{10, 8, 6, 4, 4};
        suene  = 1'b0;
        soft_clear_pulse();
        suene  = 1'b1;
        fre_up = 1'b1;
        prev   = speaker;
        for (int i = 0; i < 30; i++) begin
            advance();
            n_checks++;
            if (speaker !== m_tone || conto !== m_conto || period !== 16'(m_per)) begin
                $display("FAIL sweep_up_cyc%0d: got spk=%b period=%0d, want spk=%b period=%0d",
                         i, speaker, period, m_tone, m_per);
            end else n_pass++;
            for (int k = 0; k < 5; k++) begin
                if (exp_idx[k] == i) begin
                    n_checks++;
                    if (period !== 16'(exp_val[k])) begin
                        $display("FAIL sweep_up_step cyc%0d: got period=%0d, want %0d", i, period, exp_val[k]);
                    end else n_pass++;
                end
            end
            if (speaker !== prev) toggles.push_back(i);
            prev = speaker;
        end
        // Half-periods 10, 6, 4, 4, 4: new value only taken at each wrap.
        n_checks++;
        if (toggles.size() != 5 || toggles[0] != 9 || toggles[1] != 15 || toggles[2] != 19 ||
            toggles[3] != 23 || toggles[4] != 27) begin
            $display("FAIL sweep_up_wraps: got %0d toggles second at %0d, want toggles at 9/15/19/23/27",
                     toggles.size(), (toggles.size() > 1) ? toggles[1] : -1);
        end else n_pass++;
        fre_up = 1'b0;
        $display("[sweep_up] done");
    endtask

    task automatic test_sweep_down();
        int exp_idx[6] = '{4, 9, 14, 19, 24, 29};
        int exp_val[6] = '{12, 14, 16, 18, 20, 20};
        suene    = 1'b0;
        soft_clear_pulse();
        fre_down = 1'b1;
        for (int i = 0; i < 35; i++) begin
            advance();
            n_checks++;
            if (speaker !== m_tone || period !== 16'(m_per)) begin
                $display("FAIL sweep_down_cyc%0d: got spk=%b period=%0d, want spk=%b period=%0d",
                         i, speaker, period, m_tone, m_per);
            end else n_pass++;
            for (int k = 0; k < 6; k++) begin
                if (exp_idx[k] == i) begin
                    n_checks++;
                    if (period !== 16'(exp_val[k])) begin
                        $display("FAIL sweep_down_step cyc%0d: got period=%0d, want %0d", i, period, exp_val[k]);
                    end else n_pass++;
                end
            end
        end
        fre_up = 1'b1;
        for (int i = 0; i < 15; i++) begin
            advance();
        end
        n_checks++;
        if (period !== 16'd20 || period !== 16'(m_per)) begin
            $display("FAIL sweep_both_hold: got period=%0d, want 20", period);
        end else n_pass++;
        fre_up   = 1'b0;
        fre_down = 1'b0;
        $display("[sweep_down] done");
    endtask

    task automatic test_duration();
        int pulses[$];
        soft_clear_pulse();
        cuente = 1'b1;
        for (int i = 0; i < 27; i++) begin
            advance();
            n_checks++;
            if (conto !== m_conto) begin
                $display("FAIL dur_cont_cyc%0d: got conto=%b, want %b", i, conto, m_conto);
            end else n_pass++;
            if (conto === 1'b1) pulses.push_back(i);
        end
        n_checks++;
        if (pulses.size() != 3 || pulses[0] != 8 || pulses[1] != 16 || pulses[2] != 24) begin
            $display("FAIL dur_cont_pulses: got %0d pulses first at %0d, want pulses at 8/16/24",
                     pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
        end else n_pass++;

        pulses.delete();
        cuente = 1'b0;
        soft_clear_pulse();
        for (int i = 0; i < 26; i++) begin
            cuente = (i == 11 || i == 12) ? 1'b0 : 1'b1;
            advance();
            n_checks++;
            if (conto !== m_conto) begin
                $display("FAIL dur_restart_cyc%0d: got conto=%b, want %b", i, conto, m_conto);
            end else n_pass++;
            if (conto === 1'b1) pulses.push_back(i);
        end
        n_checks++;
        if (pulses.size() != 2 || pulses[0] != 8 || pulses[1] != 21) begin
            $display("FAIL dur_restart_pulses: got %0d pulses last at %0d, want pulses at 8/21",
                     pulses.size(), (pulses.size() > 0) ? pulses[pulses.size()-1] : -1);
        end else n_pass++;
        cuente = 1'b0;
        $display("[duration] done");
    endtask

    task automatic test_soft_clear();
        soft_clear_pulse();
        suene  = 1'b1;
        fre_up = 1'b1;
        cuente = 1'b1;
        for (int i = 0; i < 12; i++) begin
            advance();
            n_checks++;
            if (speaker !== m_tone || conto !== m_conto || period !== 16'(m_per)) begin
                $display("FAIL soft_pre_cyc%0d: got spk=%b conto=%b period=%0d, want spk=%b conto=%b period=%0d",
                         i, speaker, conto, period, m_tone, m_conto, m_per);
            end else n_pass++;
        end
        n_checks++;
        if (period !== 16'd6 || speaker !== 1'b1) begin
            $display("FAIL soft_setup: got period=%0d spk=%b, want period=6 spk=1", period, speaker);
        end else n_pass++;
        fre_up = 1'b0;
        soft_clear_pulse();
        n_checks++;
        if (period !== 16'd10 || speaker !== 1'b0 || conto !== 1'b0) begin
            $display("FAIL soft_clear: got period=%0d spk=%b conto=%b, want period=10 spk=0 conto=0", period, speaker, conto);
        end else n_pass++;
        suene  = 1'b0;
        cuente = 1'b0;
        $display("[soft_clear] done");
    endtask

    task automatic test_hard_reset();
        soft_clear_pulse();
        suene  = 1'b1;
        cuente = 1'b1;
        fre_up = 1'b1;
        for (int i = 0; i < 13; i++) begin
            advance();
        end
        n_checks++;
        if (speaker !== 1'b1 || period === 16'd10) begin
            $display("FAIL hard_setup: got spk=%b period=%0d, want spk=1 period!=10", speaker, period);
        end else n_pass++;
        fre_up = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (speaker !== 1'b0 || conto !== 1'b0 || period !== 16'd10) begin
            $display("FAIL hard_async: got spk=%b conto=%b period=%0d, want spk=0 conto=0 period=10", speaker, conto, period);
        end else n_pass++;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            advance();
            n_checks++;
            if (conto !== ((i == 8) ? 1'b1 : 1'b0) || conto !== m_conto || speaker !== m_tone) begin
                $display("FAIL hard_release_cyc%0d: got conto=%b spk=%b, want conto=%b spk=%b",
                         i, conto, speaker, (i == 8), m_tone);
            end else n_pass++;
        end
        suene  = 1'b0;
        cuente = 1'b0;
        $display("[hard_reset] done");
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_checks - n_pass;
        soft_clear_pulse();
        for (int i = 0; i < 600; i++) begin
            reset_sonido = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 15) == 0) suene = ~suene;
            if ($urandom_range(0, 7) == 0) fre_up = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) fre_down = $urandom_range(0, 1);
            cuente = ($urandom_range(0, 19) != 0);
            advance();
            n_checks++;
            if (speaker !== m_tone || conto !== m_conto || period !== 16'(m_per)) begin
                $display("FAIL random_cyc%0d: got spk=%b conto=%b period=%0d, want spk=%b conto=%b period=%0d",
                         i, speaker, conto, period, m_tone, m_conto, m_per);
            end else n_pass++;
        end
        reset_sonido = 1'b0;
        $display("[random] done, %0d new mismatches", (n_checks - n_pass) - errs_before);
    endtask

    initial begin
        RST          = 1'b1;
        reset_sonido = 1'b1;
        fre_up       = 1'b0;
        fre_down     = 1'b0;
        cuente       = 1'b0;
        suene        = 1'b0;
        model_reset();
        test_reset();
        test_tone();
        test_sweep_up();
        test_sweep_down();
        test_duration();
        test_soft_clear();
        test_hard_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sound_engine.md
SOUND_ENGINE -- requirements
Module: sound_engine

Interface
REQ-001 SHALL have parameter P_INIT, 25000, reset half-period of the tone in CLK cycles.
REQ-002 SHALL have parameter P_MIN, 5000, lower saturation bound of the half-period.
REQ-003 SHALL have parameter P_MAX, 60000, upper saturation bound of the half-period.
REQ-004 SHALL have parameter STEP, 250, half-period change per sweep tick.
REQ-005 SHALL have parameter SWEEP_DIV, 50000, CLK cycles between sweep ticks.
REQ-006 SHALL have parameter DUR, 12500000, CLK cycles per duration interval.
REQ-007 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-008 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port reset_sonido  input  1  synchronous soft clear of all sound state.
REQ-010 SHALL have port fre_up  input  1  sweep pitch up, i.e. decrease the half-period.
REQ-011 SHALL have port fre_down  input  1  sweep pitch down, i.e. increase the half-period.
REQ-012 SHALL have port cuente  input  1  enable the duration counter.
REQ-013 SHALL have port suene  input  1  gate the tone onto the speaker.
REQ-014 SHALL have port conto  output  1  one-cycle pulse at the end of each duration interval.
REQ-015 SHALL have port speaker  output  1  square-wave audio output.
REQ-016 SHALL have port period  output  16  current half-period, for debug.

Function
REQ-017 SHALL implement a state machine with three states:
- IDLE: reset_sonido=1.
- ARMED: reset_sonido=0 and suene=0.
- PLAY: reset_sonido=0 and suene=1.
Transitions SHALL be evaluated every cycle from the current inputs.
REQ-018 SHALL, while reset_sonido=1, do all of the following:
- load the half-period register with P_INIT;
- clear the sweep prescaler, tone counter, tone bit and duration counter;
- drive conto=0 and speaker=0.
reset_sonido SHALL take priority over all other inputs.
REQ-019 SHALL advance the sweep prescaler modulo SWEEP_DIV while not in IDLE, and issue a sweep tick when it wraps.
REQ-020 SHALL apply each sweep tick to the half-period register as follows:
- fre_up=1, fre_down=0: subtract STEP, saturating at P_MIN;
- fre_down=1, fre_up=0: add STEP, saturating at P_MAX;
- both 0 or both 1: hold.
REQ-021 SHALL latch a new half-period into the tone divider only when the tone counter wraps, so that no half-cycle is truncated.
REQ-022 SHALL, in PLAY, count the tone counter from 0 to active half-period minus 1, toggle the tone bit on wrap, and drive speaker equal to the tone bit.
REQ-023 SHALL, when leaving PLAY, hold the tone counter at 0, the tone bit at 0 and speaker at 0 from the next cycle onward.
REQ-024 SHALL, while cuente=1 and not in IDLE, advance the duration counter modulo DUR.
REQ-025 SHALL register conto=1 for exactly one cycle on each wrap of the duration counter, so that the first pulse occurs DUR cycles after cuente is first sampled high.
REQ-026 SHALL, when cuente=0, clear the duration counter and drive conto=0; deasserting cuente mid-interval SHALL restart the interval at 0.
REQ-027 SHALL use 16-bit unsigned arithmetic for the half-period, with saturation checked before add or subtract so that no wrap-around can occur.
REQ-028 SHALL hold conto stable across a full CLK period, so that a controller sampling on the falling edge captures it.

Reset
REQ-029 SHALL, on RST=1, asynchronously force the following until RST deasserts:
- state=IDLE;
- period=P_INIT;
- all counters to 0;
- conto=0 and speaker=0.
REQ-030 SHALL, on RST asserted mid-tone or mid-interval, abandon that tone or interval with no residual pulse after release.

Structure
REQ-031 SHALL take the state enumeration and the default parameter constants from the shared package sound_pkg.
REQ-032 SHALL contain the tone counter and tone bit in one sub-module, tone_divider, with inputs clk, rst, clr, en and half_period, and output tone.

Verification
All scenarios use the overrides P_INIT=10, P_MIN=4, P_MAX=20, STEP=2, SWEEP_DIV=5 and DUR=8.
REQ-033 SHALL check tone generation: reset_sonido=0, suene=1, no sweep -> speaker toggles every 10 cycles, giving a 20-cycle period, and period=10.
REQ-034 SHALL check sweep up: fre_up held -> period goes 10, 8, 6, 4, 4 on successive 5-cycle ticks, and the speaker half-period changes only at tone wraps.
REQ-035 SHALL check sweep down: fre_down held -> period goes 12, 14, 16, 18, 20, 20; with fre_up and fre_down both high -> period holds.
REQ-036 SHALL check duration pulsing: cuente raised at cycle 0 -> conto high only in cycles 8, 16 and 24; cuente dropped at cycle 11 and raised again at 13 -> next pulse at cycle 21.
REQ-037 SHALL check soft clear: reset_sonido pulsed mid-tone with period=6 -> next cycle period=10, speaker=0, conto=0.
REQ-038 SHALL check hard reset: RST asserted asynchronously mid-interval -> all outputs at reset values immediately, and no conto pulse after release until DUR cycles of cuente.
